// File: rtl/scl_phase_sched.sv
// -----------------------------------------------------------------------------
// scl_phase_sched
//
// Schedules a burst of SCL pulses. Each pulse is a LOW phase of (t_low+1)
// cycles followed by a HIGH phase of (t_high+1) cycles. The pulse count and
// both phase lengths are captured when the request is accepted, so the caller
// may change the inputs while the burst runs.
//
// Optional feature (macro SCL_STRETCH_EN):
//   When defined, LOW expiry goes to WAIT_HIGH. WAIT_HIGH releases SCL and
//   stays there while the sampled bus SCL (scl_i) is still low, which handles
//   clock stretching by a target. When undefined, LOW goes straight to HIGH
//   and scl_i is ignored.
//
// Parameters:
//   CNTR_W   - width of the phase counter and of t_low_i / t_high_i
//   NUM_W    - width of the pulse-count request
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   req_i    - single-cycle burst request (accepted only in IDLE, num_i != 0)
//   num_i    - number of SCL pulses in the burst
//   t_low_i  - LOW phase length minus 1, in clk cycles
//   t_high_i - HIGH phase length minus 1, in clk cycles
//   abort_i  - ends a running burst on the next cycle, without done_o
//   scl_i    - synchronized bus SCL (used only with SCL_STRETCH_EN)
//   scl_o    - SCL drive level, 1 = released/high
//   busy_o   - a burst is in progress
//   done_o   - one-cycle pulse in the first IDLE cycle after normal completion
//   phase_o  - current state encoding (IDLE=00, LOW=01, HIGH=10, WAIT_HIGH=11)
// -----------------------------------------------------------------------------
module scl_phase_sched #(
    parameter int CNTR_W = 9,
    parameter int NUM_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [NUM_W-1:0]  num_i,
    input  logic [CNTR_W-1:0] t_low_i,
    input  logic [CNTR_W-1:0] t_high_i,
    input  logic              abort_i,
    input  logic              scl_i,
    output logic              scl_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        phase_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOW       = 2'b01,
        HIGH      = 2'b10,
        WAIT_HIGH = 2'b11
    } state_t;

    localparam logic [CNTR_W-1:0] CNT_ZERO = '0;
    localparam logic [NUM_W-1:0]  NUM_ZERO = '0;
    localparam logic [NUM_W-1:0]  NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t              state_reg;
    logic [CNTR_W-1:0]   cnt_reg;
    logic [NUM_W-1:0]    rem_reg;
    logic [CNTR_W-1:0]   t_low_reg;
    logic [CNTR_W-1:0]   t_high_reg;
    logic                scl_reg;
    logic                busy_reg;
    logic                done_reg;

`ifndef SCL_STRETCH_EN
    // Without stretching the bus level is irrelevant to the schedule.
    logic unused_scl;
    assign unused_scl = scl_i;
`endif

    // The counter is loaded with (length-1) and a phase ends when it reads 0,
    // so the all-ones value yields 2^CNTR_W cycles without needing a wider
    // counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= CNT_ZERO;
            rem_reg    <= NUM_ZERO;
            t_low_reg  <= CNT_ZERO;
            t_high_reg <= CNT_ZERO;
            scl_reg    <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg != IDLE && abort_i) begin
                // Abort wins over counter expiry and any request.
                state_reg <= IDLE;
                scl_reg   <= 1'b1;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (req_i && num_i != NUM_ZERO && !abort_i) begin
                            rem_reg    <= num_i;
                            t_low_reg  <= t_low_i;
                            t_high_reg <= t_high_i;
                            cnt_reg    <= t_low_i;
                            state_reg  <= LOW;
                            scl_reg    <= 1'b0;
                            busy_reg   <= 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt_reg == CNT_ZERO) begin
                            cnt_reg <= t_high_reg;
                            scl_reg <= 1'b1;
`ifdef SCL_STRETCH_EN
                            state_reg <= WAIT_HIGH;
`else
                            state_reg <= HIGH;
`endif
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt_reg == CNT_ZERO) begin
                            rem_reg <= rem_reg - 1'b1;
                            if (rem_reg == NUM_ONE) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= LOW;
                                cnt_reg   <= t_low_reg;
                                scl_reg   <= 1'b0;
                            end
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
`ifdef SCL_STRETCH_EN
                        // Counter stays frozen until the bus actually rises.
                        if (scl_i) begin
                            state_reg <= HIGH;
                            cnt_reg   <= t_high_reg;
                        end
`else
                        // Unreachable in this build; recover to IDLE quietly.
                        state_reg <= IDLE;
                        scl_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
`endif
                    end
                    default: begin
                        state_reg <= IDLE;
                        scl_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign scl_o   = scl_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;
    assign phase_o = state_reg;

endmodule

// File: tb/tb_scl_phase_sched.sv
// -----------------------------------------------------------------------------
// tb_scl_phase_sched
//
// Directed bench for scl_phase_sched in its default build (SCL_STRETCH_EN
// undefined). Outputs are packed as {scl, busy, done, phase[1:0]} and compared
// against hand-computed values one cycle at a time.
// -----------------------------------------------------------------------------
module tb_scl_phase_sched;

    logic       clk;
    logic       rst_n;
    logic       req_i;
    logic [3:0] num_i;
    logic [8:0] t_low_i;
    logic [8:0] t_high_i;
    logic       abort_i;
    logic       scl_i;
    logic       scl_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] phase_o;

    int checks;
    int errors;

    // Packed expected output vectors {scl, busy, done, phase}
    localparam logic [4:0] O_IDLE = 5'b1_0_0_00;
    localparam logic [4:0] O_DONE = 5'b1_0_1_00;
    localparam logic [4:0] O_LOW  = 5'b0_1_0_01;
    localparam logic [4:0] O_HIGH = 5'b1_1_0_10;

    scl_phase_sched #(.CNTR_W(9), .NUM_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .num_i    (num_i),
        .t_low_i  (t_low_i),
        .t_high_i (t_high_i),
        .abort_i  (abort_i),
        .scl_i    (scl_i),
        .scl_o    (scl_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .phase_o  (phase_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, scl_o, busy_o, done_o, phase_o}, {27'd0, exp});
    endtask

    task automatic request(input logic [3:0] n, input logic [8:0] tl, input logic [8:0] th);
        req_i    = 1'b1;
        num_i    = n;
        t_low_i  = tl;
        t_high_i = th;
    endtask

    int n;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        req_i    = 1'b0;
        num_i    = '0;
        t_low_i  = '0;
        t_high_i = '0;
        abort_i  = 1'b0;
        scl_i    = 1'b1;

        // ---- reset values
        step();
        step();
        chk_out("reset", O_IDLE);
        rst_n = 1'b1;
        step();
        chk_out("after_release", O_IDLE);

        // ---- num=0 request is ignored
        request(4'd0, 9'd3, 9'd2);
        step();
        req_i = 1'b0;
        chk_out("num0_ignored", O_IDLE);

        // ---- single pulse t_low=3 t_high=2 num=1
        request(4'd1, 9'd3, 9'd2);
        step();
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("single_low%0d", i), O_LOW);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("single_high%0d", i), O_HIGH);
            step();
        end
        chk_out("single_done", O_DONE);
        step();
        chk_out("single_after", O_IDLE);

        // ---- burst t_low=0 t_high=0 num=5; timing inputs changed mid-burst
        request(4'd5, 9'd0, 9'd0);
        step();
        req_i    = 1'b0;
        t_low_i  = 9'd7;
        t_high_i = 9'd7;
        for (int p = 0; p < 5; p++) begin
            chk_out($sformatf("burst_low%0d", p), O_LOW);
            step();
            chk_out($sformatf("burst_high%0d", p), O_HIGH);
            step();
        end
        chk_out("burst_done", O_DONE);

        // ---- back-to-back: request in the done cycle, num=2 t_low=1 t_high=1.
        // req_i stays high one more cycle while busy with different values,
        // which must be ignored.
        request(4'd2, 9'd1, 9'd1);
        step();
        request(4'd9, 9'd5, 9'd5);
        chk_out("b2b_low0a", O_LOW);
        step();
        req_i = 1'b0;
        chk_out("b2b_low0b", O_LOW);
        step();
        chk_out("b2b_high0a", O_HIGH);
        step();
        chk_out("b2b_high0b", O_HIGH);
        step();
        chk_out("b2b_low1a", O_LOW);
        step();
        chk_out("b2b_low1b", O_LOW);
        step();
        chk_out("b2b_high1a", O_HIGH);
        step();
        chk_out("b2b_high1b", O_HIGH);
        step();
        chk_out("b2b_done", O_DONE);
        step();
        chk_out("b2b_idle", O_IDLE);

        // ---- abort in the 2nd LOW: num=3 t_low=2 t_high=1
        request(4'd3, 9'd2, 9'd1);
        step();
        req_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_out("abort_high0", O_HIGH);
        step();
        step();
        chk_out("abort_low1", O_LOW);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk_out("abort_idle", O_IDLE);
        step();
        chk_out("abort_no_done", O_IDLE);

        // ---- abort coincident with final HIGH expiry: no done
        request(4'd1, 9'd0, 9'd0);
        step();
        req_i = 1'b0;
        chk_out("abexp_low", O_LOW);
        step();
        chk_out("abexp_high", O_HIGH);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk_out("abexp_idle", O_IDLE);

        // ---- all-ones t_low gives 512 LOW cycles; scl_i low is ignored
        scl_i = 1'b0;
        request(4'd1, 9'h1FF, 9'd0);
        step();
        req_i = 1'b0;
        n = 0;
        while (phase_o == 2'b01 && n < 600) begin
            n++;
            step();
        end
        chk("maxlow_len", n, 512);
        chk_out("maxlow_high", O_HIGH);
        step();
        chk_out("maxlow_done", O_DONE);
        scl_i = 1'b1;
        step();

        // ---- asynchronous reset mid-HIGH: num=4 t_low=1 t_high=3
        request(4'd4, 9'd1, 9'd3);
        step();
        req_i = 1'b0;
        step();
        step();
        chk_out("rst_pre_high", O_HIGH);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", O_IDLE);
        step();
        chk_out("rst_held", O_IDLE);
        rst_n = 1'b1;
        step();
        chk_out("rst_release", O_IDLE);
        request(4'd1, 9'd0, 9'd0);
        step();
        req_i = 1'b0;
        chk_out("post_rst_low", O_LOW);
        step();
        chk_out("post_rst_high", O_HIGH);
        step();
        chk_out("post_rst_done", O_DONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
